// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the core load/store port to a req/gnt/rvalid data bus.
// Handles lane steering, misaligned accesses, load data shifting and bus timeouts.
module dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        access;
    logic        start;

    logic [3:0]  be_lane;
    logic [31:0] wdata_rep;

    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [1:0]  req_off;

    logic [7:0]  cnt;
    logic        timeout_hit;
    logic        tout;
    logic        load_rdata;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_shift;

    logic        unused_ok;

    // size[2] only selects sign handling, which the core does itself
    assign unused_ok = size[2];

    assign off     = addr[1:0];
    assign is_byte = (size[1:0] == 2'b00);
    assign is_half = (size[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;
    assign access  = rd_en | wr_en;

    assign misalign = access &
                      ((is_half & off[0]) |
                       (is_word & (off != 2'b00)));

    assign start = (state == IDLE) & access & !misalign;

    always_comb begin
        be_lane   = 4'b1111;
        wdata_rep = wdata;
        unique case (1'b1)
            is_byte: begin
                be_lane   = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            is_half: begin
                be_lane   = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be_lane   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // request fields are frozen at launch so the bus sees a stable beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
            req_off   <= '0;
        end else if (start) begin
            req_addr  <= {addr[31:2], 2'b00};
            req_we    <= wr_en;
            req_be    <= wr_en ? be_lane : 4'b0000;
            req_wdata <= wdata_rep;
            req_off   <= off;
        end
    end

    assign timeout_hit = (cnt >= TMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // a completing event wins only if it lands inside the timeout budget
    always_comb begin
        state_nxt  = state;
        tout       = 1'b0;
        load_rdata = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus_gnt && req_we) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tout      = 1'b1;
                end else if (bus_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    state_nxt  = DONE;
                    load_rdata = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tout      = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign rdata_shift = bus_rdata >> {req_off, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tout;
            if (start || tout) begin
                rdata_q <= '0;
            end else if (load_rdata) begin
                rdata_q <= rdata_shift;
            end
        end
    end

    assign rdata     = misalign ? 32'h0 : rdata_q;
    assign bus_err   = err_q;
    assign stall     = start | (state == REQ) | (state == WAIT);
    assign bus_req   = (state == REQ);
    assign bus_we    = req_we;
    assign bus_addr  = req_addr;
    assign bus_be    = req_be;
    assign bus_wdata = req_wdata;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255; maximum cycles spent in REQ plus WAIT before the access is aborted.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 rd_en  input  1  core load request, held stable while stall=1.
REQ-005 wr_en  input  1  core store request, held stable while stall=1.
REQ-006 addr  input  32  byte address (ALU result).
REQ-007 wdata  input  32  store data, LSB-aligned.
REQ-008 size  input  3  func3 encoding: 000/100 byte, 001/101 half, 010 word.
REQ-009 rdata  output  32  load data shifted so the addressed byte sits at [7:0], not sign-extended.
REQ-010 stall  output  1  freezes PC and register-file write while high.
REQ-011 misalign  output  1  combinational misaligned-access flag.
REQ-012 bus_err  output  1  one-cycle pulse when an access times out.
REQ-013 bus_req  output  1  bus request valid.
REQ-014 bus_we  output  1  1 = write, 0 = read.
REQ-015 bus_addr  output  32  {addr[31:2], 2'b00}.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_be  output  4  byte enables.
REQ-018 bus_gnt  input  1  bus accepts the request this cycle.
REQ-019 bus_rvalid  input  1  read data valid.
REQ-020 bus_rdata  input  32  read data word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE SHALL be used.
REQ-022 IDLE->REQ when (rd_en|wr_en) & !misalign; otherwise remain IDLE.
REQ-023 REQ: bus_req=1; on bus_gnt, write -> DONE, read -> WAIT.
REQ-024 WAIT: on bus_rvalid capture bus_rdata >> (8*addr[1:0]) into rdata register, -> DONE; bus_rvalid outside WAIT ignored.
REQ-025 DONE: stall=0 for exactly one cycle, rdata valid; unconditional -> IDLE.
REQ-026 stall = (IDLE & (rd_en|wr_en) & !misalign) | REQ | WAIT.
REQ-027 misalign=1 for half with addr[0]=1 or word with addr[1:0]!=0; no bus transaction, stall=0, rdata=0.
REQ-028 bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; bus_be=0 for reads.
REQ-029 bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-030 rd_en and wr_en both high SHALL be treated as a write.
REQ-031 8-bit cycle counter cleared on IDLE->REQ, increments in REQ/WAIT; at TIMEOUT -> DONE with bus_err=1 in DONE, rdata=0, bus_req dropped.
REQ-032 bus_addr, bus_we, bus_be, bus_wdata SHALL be stable while bus_req=1.
REQ-033 Minimum latency: store 2 cycles of stall (IDLE, REQ with gnt), load 3 with gnt and rvalid on consecutive cycles.

Reset
REQ-034 On reset: state=IDLE, counter=0, rdata=0, bus_req=0, bus_err=0, stall reflects only REQ-026 IDLE term.
REQ-035 Reset asserted in REQ or WAIT SHALL drop bus_req in the same cycle and abandon the access; a late bus_rvalid SHALL be ignored.

Verification
REQ-036 sw addr=0x100 wdata=0xDEADBEEF, gnt after 2 cycles -> bus_we=1, bus_be=1111, stall high 3 cycles then low 1 cycle.
REQ-037 lb addr=0x103, bus_rdata=0x80AA55CC -> rdata=0x00000080, bus_be=0.
REQ-038 sh addr=0x102 wdata=0x1234 -> bus_wdata=0x12341234, bus_be=1100.
REQ-039 lw addr=0x101 -> misalign=1, bus_req never asserted, stall=0.
REQ-040 lw with bus_gnt never asserted -> bus_err pulse after TIMEOUT cycles, rdata=0, FSM returns IDLE.
REQ-041 reset pulsed in WAIT, then bus_rvalid -> bus_req=0 immediately, rdata remains 0, state IDLE.
